// File: rtl/halt_drain_monitor.sv
// End-of-test detector: accepts a stop request, waits for all pipeline stages to stay idle
// for QUIET_CYCLES consecutive cycles, and bounds the drain with a watchdog. Macro: SIM_FINISH_EN.
module halt_drain_monitor #(
    parameter int NSTAGES      = 5,
    parameter int QUIET_CYCLES = 2,
    parameter int TIMEOUT      = 4096,
    parameter int CODE_W       = 8,
    parameter int CNT_W        = 16
) (
    input  logic               clk_core,
    input  logic               reset,
    input  logic               stop_req,
    input  logic [CODE_W-1:0]  stop_code,
    input  logic [NSTAGES-1:0] stage_valid,
    input  logic [NSTAGES-1:0] stage_exc,
    output logic               busy,
    output logic               halted,
    output logic               timed_out,
    output logic [CODE_W-1:0]  exit_code,
    output logic [CNT_W-1:0]   drain_cycles
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_RUN, S_DRAIN, S_QUIET, S_DONE, S_TMO} state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] quiet_cnt, quiet_nxt;
    logic [WW-1:0] wdog;
    logic          idle, wdog_exp;

    assign idle     = ~|stage_valid & ~|stage_exc;
    assign wdog_exp = (wdog == WW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        quiet_nxt = quiet_cnt;
        case (state)
            S_RUN: begin
                if (stop_req) begin
                    state_nxt = S_DRAIN;
                    quiet_nxt = '0;
                end
            end
            S_DRAIN: begin
                if (idle) begin
                    quiet_nxt = QW'(1);
                    state_nxt = (QUIET_CYCLES == 1) ? S_DONE : S_QUIET;
                end
                // completion on the watchdog's last cycle still counts as DONE
                if (state_nxt != S_DONE && wdog_exp) state_nxt = S_TMO;
            end
            S_QUIET: begin
                if (idle) begin
                    quiet_nxt = quiet_cnt + QW'(1);
                    if (quiet_cnt == QW'(QUIET_CYCLES - 1)) state_nxt = S_DONE;
                end else begin
                    quiet_nxt = '0;
                    state_nxt = S_DRAIN;
                end
                if (state_nxt != S_DONE && wdog_exp) state_nxt = S_TMO;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            state        <= S_RUN;
            quiet_cnt    <= '0;
            wdog         <= '0;
            exit_code    <= '0;
            drain_cycles <= '0;
        end else begin
            state     <= state_nxt;
            quiet_cnt <= quiet_nxt;
            if (state == S_RUN && stop_req) begin
                exit_code    <= stop_code;
                drain_cycles <= '0;
                wdog         <= '0;
            end else if (state == S_DRAIN || state == S_QUIET) begin
                wdog <= wdog + WW'(1);
                if (drain_cycles != '1) drain_cycles <= drain_cycles + CNT_W'(1);
            end
        end
    end

    assign busy      = (state == S_DRAIN) || (state == S_QUIET);
    assign halted    = (state == S_DONE);
    assign timed_out = (state == S_TMO);

`ifdef SIM_FINISH_EN
    always_ff @(posedge clk_core) begin
        if (!reset) begin
            if (state == S_DONE) begin
                $display("PASS code=%0h cycles=%0d", exit_code, drain_cycles);
                $finish;
            end
            if (state != S_TMO && state_nxt == S_TMO) begin
                $display("TIMEOUT code=%0h cycles=%0d", exit_code, drain_cycles);
                $fatal(1, "drain watchdog expired");
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_halt_drain_monitor.sv
// Directed bench for halt_drain_monitor; several parameterisations share one stimulus stream
// and halt results are checked against a scoreboard of expected latency/code/drain length.
module tb_halt_drain_monitor;
    logic       clk_core = 0;
    logic       reset = 1;
    logic       stop_req = 0;
    logic [7:0] stop_code = '0;
    logic [4:0] stage_valid = '0;
    logic [4:0] stage_exc = '0;

    logic        busy_a, halted_a, timed_a, busy_b, halted_b, timed_b;
    logic        busy_c, halted_c, timed_c, busy_d, halted_d, timed_d;
    logic        busy_e, halted_e, timed_e;
    logic [7:0]  code_a, code_b, code_c, code_d, code_e;
    logic [15:0] drain_a, drain_b, drain_c, drain_d;
    logic [2:0]  drain_e;

    halt_drain_monitor u_a (.clk_core(clk_core), .reset(reset), .stop_req(stop_req),
        .stop_code(stop_code), .stage_valid(stage_valid), .stage_exc(stage_exc), .busy(busy_a),
        .halted(halted_a), .timed_out(timed_a), .exit_code(code_a), .drain_cycles(drain_a));
    halt_drain_monitor #(.TIMEOUT(16)) u_b (.clk_core(clk_core), .reset(reset), .stop_req(stop_req),
        .stop_code(stop_code), .stage_valid(stage_valid), .stage_exc(stage_exc), .busy(busy_b),
        .halted(halted_b), .timed_out(timed_b), .exit_code(code_b), .drain_cycles(drain_b));
    halt_drain_monitor #(.TIMEOUT(3)) u_c (.clk_core(clk_core), .reset(reset), .stop_req(stop_req),
        .stop_code(stop_code), .stage_valid(stage_valid), .stage_exc(stage_exc), .busy(busy_c),
        .halted(halted_c), .timed_out(timed_c), .exit_code(code_c), .drain_cycles(drain_c));
    halt_drain_monitor #(.TIMEOUT(2)) u_d (.clk_core(clk_core), .reset(reset), .stop_req(stop_req),
        .stop_code(stop_code), .stage_valid(stage_valid), .stage_exc(stage_exc), .busy(busy_d),
        .halted(halted_d), .timed_out(timed_d), .exit_code(code_d), .drain_cycles(drain_d));
    halt_drain_monitor #(.CNT_W(3)) u_e (.clk_core(clk_core), .reset(reset), .stop_req(stop_req),
        .stop_code(stop_code), .stage_valid(stage_valid), .stage_exc(stage_exc), .busy(busy_e),
        .halted(halted_e), .timed_out(timed_e), .exit_code(code_e), .drain_cycles(drain_e));

    always #5 clk_core = ~clk_core;

    int cyc = 0;
    always @(posedge clk_core) cyc <= cyc + 1;

    typedef struct {
        int         lat;
        logic [7:0] code;
        logic [15:0] cycles;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; stop_req = 0; stage_valid = '0; stage_exc = '0;
        step(); step();
        reset = 0;
    endtask

    // issue a stop and return the cycle index of acceptance
    task automatic accept(input logic [7:0] code, output int acc);
        stop_req = 1; stop_code = code;
        step();
        acc = cyc;
        stop_req = 0;
    endtask

    task automatic wait_halt(input string tag, input int acc);
        exp_t e;
        int n = 0;
        while (!halted_a && n < 60) begin step(); n++; end
        e = sb.pop_front();
        if (!halted_a) chk({tag, "_halt_wait"}, 0, 1);
        else begin
            chk({tag, "_latency"}, cyc - acc, e.lat);
            chk({tag, "_exit_code"}, code_a, e.code);
            chk({tag, "_drain"}, drain_a, e.cycles);
            chk({tag, "_timed_out"}, timed_a, 0);
            chk({tag, "_busy"}, busy_a, 0);
        end
    endtask

    initial begin
        int acc;
        int n;
        step(); step();
        chk("rst_busy", busy_a, 0);
        chk("rst_halted", halted_a, 0);
        chk("rst_timed", timed_a, 0);
        chk("rst_code", code_a, 0);
        chk("rst_drain", drain_a, 0);
        reset = 0;
        step();
        chk("run_busy", busy_a, 0);

        // 1: idle pipe, minimum latency
        accept(8'h5A, acc);
        sb.push_back('{2, 8'h5A, 16'd2});
        chk("t1_busy_next", busy_a, 1);
        chk("t1_halted_next", halted_a, 0);
        wait_halt("t1", acc);

        // 2: stage 2 busy for 10 cycles after acceptance
        do_reset();
        stage_valid = 5'b00100;
        accept(8'h21, acc);
        sb.push_back('{12, 8'h21, 16'd12});
        repeat (10) step();
        stage_valid = '0;
        wait_halt("t2", acc);
        chk("t2_sat_drain", drain_e, 3'd7);
        chk("t2_sat_halted", halted_e, 1);
        // terminal state ignores everything
        stop_req = 1; stop_code = 8'h99; stage_valid = 5'b11111;
        repeat (3) step();
        stop_req = 0; stage_valid = '0;
        chk("t2_frozen_halted", halted_a, 1);
        chk("t2_frozen_code", code_a, 8'h21);
        chk("t2_frozen_drain", drain_a, 16'd12);

        // 3: one-cycle exception glitch restarts the quiet window
        do_reset();
        accept(8'h3C, acc);
        sb.push_back('{4, 8'h3C, 16'd4});
        step();
        stage_exc = 5'b10000;
        step();
        stage_exc = '0;
        chk("t3_busy_glitch", busy_a, 1);
        wait_halt("t3", acc);

        // 4: stuck stage against a 16-cycle watchdog
        do_reset();
        stage_valid = 5'b00001;
        accept(8'h44, acc);
        n = 0;
        while (!timed_b && n < 40) begin step(); n++; end
        chk("t4_timed_out", timed_b, 1);
        chk("t4_latency", cyc - acc, 16);
        chk("t4_halted", halted_b, 0);
        chk("t4_busy", busy_b, 0);
        chk("t4_long_wdog_busy", busy_a, 1);
        step();
        chk("t4_sticky", timed_b, 1);
        stage_valid = '0;

        // 5: second stop ignored, reset mid-QUIET aborts, fresh stop afterwards
        do_reset();
        stage_valid = 5'b00010;
        accept(8'hC1, acc);
        stop_req = 1; stop_code = 8'h33;
        step();
        stop_req = 0;
        chk("t5_code_kept", code_a, 8'hC1);
        chk("t5_busy", busy_a, 1);
        stage_valid = '0;
        step();
        reset = 1;
        step();
        chk("t5_rst_busy", busy_a, 0);
        chk("t5_rst_halted", halted_a, 0);
        chk("t5_rst_timed", timed_a, 0);
        chk("t5_rst_code", code_a, 0);
        chk("t5_rst_drain", drain_a, 0);
        reset = 0;
        accept(8'h77, acc);
        sb.push_back('{2, 8'h77, 16'd2});
        wait_halt("t5", acc);

        // 6: completion and watchdog expiry on the same cycle
        do_reset();
        accept(8'h66, acc);
        n = 0;
        while (!halted_d && !timed_d && n < 20) begin step(); n++; end
        chk("t6_d_halted", halted_d, 1);
        chk("t6_d_timed", timed_d, 0);
        chk("t6_d_latency", cyc - acc, 2);
        chk("t6_c_halted", halted_c, 1);
        chk("t6_c_timed", timed_c, 0);
        step();
        chk("t6_d_sticky", halted_d, 1);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
